// File: rtl/usb_tx_lp_buffer.sv
// Store-and-forward byte buffer: accepts packet bytes from the token stage and
// hands only complete, well-formed packets to transmit_control.
module usb_tx_lp_buffer #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    in_data,
  input  logic          in_sop,
  input  logic          in_eop,
  input  logic          in_enable,
  input  logic          fifo_rst,
  output logic [7:0]    tx_lp_data,
  output logic          tx_lp_sop,
  output logic          tx_lp_eop,
  output logic          tx_lp_valid,
  input  logic          tx_lp_ready,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   pkt_cnt,
  output logic          overflow,
  output logic          frame_err
);

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_PKT,
    WR_DROP
  } wr_state_e;

  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [9:0]  mem_q [DEPTH];

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] commit_ptr_q, commit_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] pkt_cnt_q, pkt_cnt_d;
  logic        overflow_q, overflow_d;
  logic        frame_err_q, frame_err_d;
  wr_state_e   state_q, state_d;

  logic [AW:0] fill;
  logic [AW:0] wr_addr;
  logic [9:0]  head;
  logic        full_w;
  logic        empty_w;
  logic        pop;
  logic        accept;
  logic        wr_en;
  logic        commit;

  assign fill    = wr_ptr_q - rd_ptr_q;
  assign full_w  = (fill == FULL_CNT);
  assign empty_w = (rd_ptr_q == commit_ptr_q);
  assign pop     = ~empty_w & tx_lp_ready;
  assign head    = mem_q[rd_ptr_q[AW-1:0]];

  assign tx_lp_sop   = head[9];
  assign tx_lp_eop   = head[8];
  assign tx_lp_data  = head[7:0];
  assign tx_lp_valid = ~empty_w;
  assign full        = full_w;
  assign empty       = empty_w;
  assign pkt_cnt     = pkt_cnt_q;
  assign overflow    = overflow_q;
  assign frame_err   = frame_err_q;

  // A sop inside an open packet rewinds the write address to commit_ptr so
  // the new packet overwrites the abandoned partial one in the same cycle.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    pkt_cnt_d    = pkt_cnt_q;
    overflow_d   = overflow_q;
    frame_err_d  = frame_err_q;
    state_d      = state_q;
    wr_addr      = wr_ptr_q;
    accept       = 1'b0;
    wr_en        = 1'b0;
    commit       = 1'b0;

    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    if (in_enable) begin
      case (state_q)
        WR_IDLE: begin
          if (in_sop) begin
            accept = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        WR_PKT: begin
          accept = 1'b1;
          if (in_sop) begin
            frame_err_d = 1'b1;
            wr_addr     = commit_ptr_q;
          end
        end
        WR_DROP: begin
          accept = in_sop;
        end
        default: begin
          accept = 1'b0;
        end
      endcase

      if (accept) begin
        if (full_w) begin
          overflow_d = 1'b1;
          wr_ptr_d   = commit_ptr_q;
          state_d    = WR_DROP;
        end else begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_addr + 1'b1;
          if (in_eop) begin
            commit       = 1'b1;
            commit_ptr_d = wr_addr + 1'b1;
            state_d      = WR_IDLE;
          end else begin
            state_d = WR_PKT;
          end
        end
      end
    end

    if (commit && !(pop && head[8])) begin
      pkt_cnt_d = pkt_cnt_q + 1'b1;
    end else if (!commit && pop && head[8]) begin
      pkt_cnt_d = pkt_cnt_q - 1'b1;
    end

    if (fifo_rst) begin
      wr_ptr_d     = '0;
      commit_ptr_d = '0;
      rd_ptr_d     = '0;
      pkt_cnt_d    = '0;
      overflow_d   = 1'b0;
      frame_err_d  = 1'b0;
      state_d      = WR_IDLE;
      wr_en        = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      pkt_cnt_q    <= '0;
      overflow_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      state_q      <= WR_IDLE;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pkt_cnt_q    <= pkt_cnt_d;
      overflow_q   <= overflow_d;
      frame_err_q  <= frame_err_d;
      state_q      <= state_d;
    end
  end

  // Storage is intentionally left out of reset; only pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr[AW-1:0]] <= {in_sop, in_eop, in_data};
    end
  end

endmodule

// File: tb/tb_usb_tx_lp_buffer.sv
// Testbench for usb_tx_lp_buffer: directed packet scenarios with literal
// expectations plus randomized traffic checked against a queue-based model.
module tb_usb_tx_lp_buffer;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    in_data;
  logic          in_sop;
  logic          in_eop;
  logic          in_enable;
  logic          fifo_rst;
  logic [7:0]    tx_lp_data;
  logic          tx_lp_sop;
  logic          tx_lp_eop;
  logic          tx_lp_valid;
  logic          tx_lp_ready;
  logic          full;
  logic          empty;
  logic [AW:0]   pkt_cnt;
  logic          overflow;
  logic          frame_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  usb_tx_lp_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_sop      (in_sop),
    .in_eop      (in_eop),
    .in_enable   (in_enable),
    .fifo_rst    (fifo_rst),
    .tx_lp_data  (tx_lp_data),
    .tx_lp_sop   (tx_lp_sop),
    .tx_lp_eop   (tx_lp_eop),
    .tx_lp_valid (tx_lp_valid),
    .tx_lp_ready (tx_lp_ready),
    .full        (full),
    .empty       (empty),
    .pkt_cnt     (pkt_cnt),
    .overflow    (overflow),
    .frame_err   (frame_err)
  );

  // Model: committed bytes waiting for transmit, plus the open partial packet.
  typedef enum {M_IDLE, M_PKT, M_DROP} mode_t;
  logic [9:0] committed_q[$];
  logic [9:0] partial_q[$];
  mode_t      model_mode;
  bit         model_ovf;
  bit         model_ferr;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelClear();
    committed_q.delete();
    partial_q.delete();
    model_mode = M_IDLE;
    model_ovf  = 1'b0;
    model_ferr = 1'b0;
  endtask

  function automatic int modelPackets();
    int n = 0;
    foreach (committed_q[k]) if (committed_q[k][8]) n++;
    return n;
  endfunction

  task automatic modelStep();
    bit         full_pre;
    bit         do_pop;
    logic [9:0] b;
    full_pre = (committed_q.size() + partial_q.size()) == DEPTH;
    do_pop   = (committed_q.size() > 0) && tx_lp_ready;
    b        = {in_sop, in_eop, in_data};
    if (do_pop) void'(committed_q.pop_front());
    if (in_enable) begin
      if (in_sop && model_mode == M_PKT) begin
        model_ferr = 1'b1;
        partial_q.delete();
      end
      if (!in_sop && model_mode == M_IDLE) begin
        model_ferr = 1'b1;
      end else if (!in_sop && model_mode == M_DROP) begin
        model_mode = M_DROP;
      end else if (full_pre) begin
        model_ovf  = 1'b1;
        partial_q.delete();
        model_mode = M_DROP;
      end else begin
        partial_q.push_back(b);
        if (in_eop) begin
          foreach (partial_q[k]) committed_q.push_back(partial_q[k]);
          partial_q.delete();
          model_mode = M_IDLE;
        end else begin
          model_mode = M_PKT;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    if (!rst || fifo_rst) modelClear();
    else modelStep();
  end

  // Every negedge: all outputs against the model (head byte only when valid).
  always @(negedge clk) begin
    int  occ;
    bit  mvalid;
    if (!rst) modelClear();
    occ    = committed_q.size() + partial_q.size();
    mvalid = committed_q.size() > 0;
    checkOutput("valid", int'(tx_lp_valid), int'(mvalid));
    checkOutput("empty", int'(empty), int'(!mvalid));
    checkOutput("full", int'(full), int'(occ == DEPTH));
    checkOutput("pkt_cnt", int'(pkt_cnt), modelPackets());
    checkOutput("overflow", int'(overflow), int'(model_ovf));
    checkOutput("frame_err", int'(frame_err), int'(model_ferr));
    if (mvalid) begin
      checkOutput("head", int'({tx_lp_sop, tx_lp_eop, tx_lp_data}), int'(committed_q[0]));
    end
  end

  task automatic applyStimulus(input logic [7:0] d, input logic s, input logic e,
                               input logic en, input logic rdy, input logic frst);
    in_data     = d;
    in_sop      = s;
    in_eop      = e;
    in_enable   = en;
    tx_lp_ready = rdy;
    fifo_rst    = frst;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n, input logic rdy);
    for (int k = 0; k < n; k++) applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, rdy, 1'b0);
  endtask

  initial begin
    int  ready_pct;
    bit  open;
    logic s, e, en;
    rst = 1'b0;
    in_data = 8'h00; in_sop = 1'b0; in_eop = 1'b0; in_enable = 1'b0;
    fifo_rst = 1'b0; tx_lp_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    checkOutput("rst_empty", int'(empty), 1);
    checkOutput("rst_full", int'(full), 0);
    checkOutput("rst_valid", int'(tx_lp_valid), 0);
    checkOutput("rst_pkt_cnt", int'(pkt_cnt), 0);
    rst = 1'b1;
    idleCycles(2, 1'b0);

    $display("[TB] token packet");
    applyStimulus(8'h69, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("tok_not_valid_early", int'(tx_lp_valid), 0);
    applyStimulus(8'h81, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(8'h2A, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("tok_valid", int'(tx_lp_valid), 1);
    checkOutput("tok_b0", int'({tx_lp_sop, tx_lp_eop, tx_lp_data}), 'h269);
    checkOutput("tok_cnt1", int'(pkt_cnt), 1);
    idleCycles(1, 1'b1);
    checkOutput("tok_b1", int'({tx_lp_sop, tx_lp_eop, tx_lp_data}), 'h081);
    idleCycles(1, 1'b1);
    checkOutput("tok_b2", int'({tx_lp_sop, tx_lp_eop, tx_lp_data}), 'h12A);
    idleCycles(1, 1'b1);
    checkOutput("tok_empty", int'(empty), 1);
    checkOutput("tok_cnt0", int'(pkt_cnt), 0);

    $display("[TB] handshake held");
    applyStimulus(8'hD2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    idleCycles(5, 1'b0);
    checkOutput("hs_valid", int'(tx_lp_valid), 1);
    checkOutput("hs_data", int'(tx_lp_data), 'hD2);
    checkOutput("hs_cnt", int'(pkt_cnt), 1);
    idleCycles(1, 1'b1);
    checkOutput("hs_empty", int'(empty), 1);

    $display("[TB] overflow");
    for (int p = 0; p < 3; p++) begin
      applyStimulus(8'(8'h10 + p), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(8'(8'h20 + p), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      if (p == 2) begin
        checkOutput("ovf_full8", int'(full), 1);
        checkOutput("ovf_cnt2", int'(pkt_cnt), 2);
      end
      applyStimulus(8'(8'h30 + p), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    checkOutput("ovf_flag", int'(overflow), 1);
    checkOutput("ovf_full_after", int'(full), 0);
    checkOutput("ovf_cnt_after", int'(pkt_cnt), 2);
    idleCycles(5, 1'b1);
    checkOutput("ovf_last_byte", int'({tx_lp_sop, tx_lp_eop, tx_lp_data}), 'h131);
    idleCycles(1, 1'b1);
    checkOutput("ovf_drained", int'(empty), 1);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("ovf_cleared", int'(overflow), 0);

    $display("[TB] sop inside packet");
    applyStimulus(8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h33, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h44, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("fe_flag", int'(frame_err), 1);
    checkOutput("fe_cnt", int'(pkt_cnt), 1);
    checkOutput("fe_head", int'({tx_lp_sop, tx_lp_eop, tx_lp_data}), 'h233);
    idleCycles(1, 1'b1);
    checkOutput("fe_b1", int'(tx_lp_data), 'h44);
    idleCycles(1, 1'b1);
    checkOutput("fe_b2", int'({tx_lp_sop, tx_lp_eop, tx_lp_data}), 'h155);
    idleCycles(1, 1'b1);
    checkOutput("fe_empty", int'(empty), 1);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("[TB] stray byte in idle");
    applyStimulus(8'h77, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("stray_ferr", int'(frame_err), 1);
    checkOutput("stray_empty", int'(empty), 1);

    $display("[TB] flush with traffic");
    applyStimulus(8'hA1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'hB1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'hB2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("fl_cnt2", int'(pkt_cnt), 2);
    applyStimulus(8'hC1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("fl_empty", int'(empty), 1);
    checkOutput("fl_cnt0", int'(pkt_cnt), 0);
    checkOutput("fl_ferr", int'(frame_err), 0);
    checkOutput("fl_ovf", int'(overflow), 0);

    $display("[TB] async reset mid-packet");
    applyStimulus(8'hE1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    in_enable = 1'b0;
    #2 rst = 1'b0;
    #1;
    checkOutput("ar_empty", int'(empty), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    applyStimulus(8'hE2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("ar_ferr", int'(frame_err), 1);
    checkOutput("ar_still_empty", int'(empty), 1);

    $display("[TB] random traffic");
    open = 1'b0;
    ready_pct = 70;
    for (int i = 0; i < 4000; i++) begin
      if (i % 400 == 0) ready_pct = int'($urandom_range(0, 100));
      en = ($urandom_range(0, 9) < 7);
      s  = open ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 9) != 0);
      e  = ($urandom_range(0, 3) == 0);
      if (en && (s || open)) open = !e;
      applyStimulus(8'($urandom), s, e, en,
                    ($urandom_range(0, 99) < ready_pct), ($urandom_range(0, 299) == 0));
    end
    idleCycles(20, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
